control_unit: RTL and testbench

Hardwired control sequencer for the 32-bit bus-based CPU. It steps through fetch (T0–T2) and per-class execute steps (T3–T7), and drives every register-enable, bus-drive, memory and ALU-select line of `datapath`. It replaces the hand-timed control sequences used in the datapath testbenches. It takes the IR contents back from the datapath and runs one control step per clock.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/op_class_decode.sv | 29 ++
 rtl/control_unit.sv | 144 ++++++++++++++
 tb/tb_control_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-based CPU: opcodes, IR field positions,
// control-sequencer states and instruction classes.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = OP_ADD;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RA_MSB  = 26;
    localparam int unsigned RA_LSB  = 23;
    localparam int unsigned RB_MSB  = 22;
    localparam int unsigned RB_LSB  = 19;
    localparam int unsigned RC_MSB  = 18;
    localparam int unsigned RC_LSB  = 15;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_ALU_RR, C_ALU_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_NOP, C_HALT
    } op_class_e;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode-to-class map; unlisted opcodes fall into the nop class.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [4:0] opcode_i,
    output logic [3:0] op_class_o
);

    op_class_e cls;

    always_comb begin
        cls = C_NOP;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  cls = C_ALU_RR;
            OP_ADDI, OP_ANDI, OP_ORI:         cls = C_ALU_IMM;
            OP_NEG, OP_NOT:                   cls = C_UNARY;
            OP_MUL, OP_DIV:                   cls = C_MULDIV;
            OP_LD:                            cls = C_LD;
            OP_LDI:                           cls = C_LDI;
            OP_ST:                            cls = C_ST;
            OP_HALT:                          cls = C_HALT;
            default:                          cls = C_NOP;
        endcase
    end

    assign op_class_o = cls;

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch T0-T2, class-specific execute T3-T7,
// with pause/halt handling at instruction boundaries.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  alu_op,
    output logic        Run
);

    state_e     state_q, state_d;
    logic       halted_q, halted_d;
    logic [4:0] opcode;
    logic [3:0] class_raw;
    op_class_e  cls;
    logic       last_step;
    logic       unused_ir;

    assign opcode    = IR[OPC_MSB:OPC_LSB];
    assign unused_ir = ^IR[OPC_LSB-1:0];

    op_class_decode u_decode (
        .opcode_i   (opcode),
        .op_class_o (class_raw)
    );

    assign cls = op_class_e'(class_raw);

    always_comb begin
        last_step = 1'b0;
        case (state_q)
            S_T2:    last_step = (cls == C_NOP);
            S_T4:    last_step = (cls == C_UNARY);
            S_T5:    last_step = cls inside {C_ALU_RR, C_ALU_IMM, C_LDI};
            S_T6:    last_step = (cls == C_MULDIV);
            S_T7:    last_step = 1'b1;
            default: last_step = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_HALT:  if (!halted_q && !Stop) state_d = S_T0;
            default: begin
                if (state_q == S_T2 && cls == C_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (last_step) begin
                    state_d = Stop ? S_HALT : S_T0;
                end else begin
                    state_d = state_e'(state_q + 4'd1);
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_RESET;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Moore decode of state; execute steps also look at the live IR class.
    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC}       = '0;
        {Gra, Grb, Grc, Rin, Rout, Read, Write}                       = '0;
        alu_op = '0;
        Run    = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: case (cls)
                C_ALU_RR, C_ALU_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                C_UNARY:  begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                C_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                default: ;
            endcase
            S_T4: case (cls)
                C_ALU_RR: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                C_ALU_IMM: begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                C_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                C_LD, C_LDI, C_ST: begin Cout = 1'b1; Zin = 1'b1; alu_op = ALU_ADD; end
                default: ;
            endcase
            S_T5: case (cls)
                C_ALU_RR, C_ALU_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                C_MULDIV:   begin Zlowout = 1'b1; LOin = 1'b1; end
                C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                default: ;
            endcase
            S_T6: case (cls)
                C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                default: ;
            endcase
            S_T7: case (cls)
                C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                C_ST:    Write = 1'b1;
                default: ;
            endcase
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized instruction/Stop/reset stimulus checked cycle by cycle against
// a step-table model of the control sequencer.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Stop = 1'b0;
    logic [31:0] IR = '0;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC;
    logic Gra, Grb, Grc, Rin, Rout, Read, Write, Run;
    logic [4:0] alu_op;

    control_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run)
    );

    always #5 Clock = ~Clock;

    logic [28:0] obs_word;
    assign obs_word = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout,
                       PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC,
                       Gra, Grb, Grc, Rin, Rout, Read, Write, alu_op};

    localparam logic [28:0] M_WRITE = 29'd1 << 5,  M_READ  = 29'd1 << 6;
    localparam logic [28:0] M_ROUT  = 29'd1 << 7,  M_RIN   = 29'd1 << 8;
    localparam logic [28:0] M_GRC   = 29'd1 << 9,  M_GRB   = 29'd1 << 10;
    localparam logic [28:0] M_GRA   = 29'd1 << 11, M_INCPC = 29'd1 << 12;
    localparam logic [28:0] M_LOIN  = 29'd1 << 13, M_HIIN  = 29'd1 << 14;
    localparam logic [28:0] M_ZIN   = 29'd1 << 15, M_YIN   = 29'd1 << 16;
    localparam logic [28:0] M_IRIN  = 29'd1 << 17, M_MDRIN = 29'd1 << 18;
    localparam logic [28:0] M_MARIN = 29'd1 << 19, M_PCIN  = 29'd1 << 20;
    localparam logic [28:0] M_BAOUT = 29'd1 << 21, M_COUT  = 29'd1 << 22;
    localparam logic [28:0] M_MDROUT = 29'd1 << 25, M_ZLOW = 29'd1 << 26;
    localparam logic [28:0] M_ZHIGH = 29'd1 << 27, M_PCOUT = 29'd1 << 28;

    typedef enum {K_RR, K_IMM, K_UN, K_MD, K_LD, K_LDI, K_ST, K_NOP, K_HALT} kind_t;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [4:0] op);
        int unsigned v = int'(op);
        if (v >= 3 && v <= 11)  return K_RR;
        if (v >= 12 && v <= 14) return K_IMM;
        if (v == 15 || v == 16) return K_MD;
        if (v == 17 || v == 18) return K_UN;
        if (v == 0)  return K_LD;
        if (v == 1)  return K_LDI;
        if (v == 2)  return K_ST;
        if (v == 27) return K_HALT;
        return K_NOP;
    endfunction

    function automatic int unsigned inst_len(input logic [4:0] op);
        case (kind_of(op))
            K_NOP, K_HALT:      return 3;
            K_UN:               return 5;
            K_RR, K_IMM, K_LDI: return 6;
            K_MD:               return 7;
            default:            return 8;
        endcase
    endfunction

    function automatic logic [28:0] exp_word(input logic [4:0] op, input int unsigned k);
        kind_t       kd = kind_of(op);
        logic [28:0] aluf = {24'd0, op};
        logic [28:0] w = '0;
        case (k)
            0: w = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
            1: w = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
            2: w = M_MDROUT | M_IRIN;
            3: case (kd)
                K_RR, K_IMM:      w = M_GRB | M_ROUT | M_YIN;
                K_UN:             w = M_GRB | M_ROUT | M_ZIN | aluf;
                K_MD:             w = M_GRA | M_ROUT | M_YIN;
                K_LD, K_LDI, K_ST: w = M_GRB | M_BAOUT | M_YIN;
                default: ;
            endcase
            4: case (kd)
                K_RR:             w = M_GRC | M_ROUT | M_ZIN | aluf;
                K_IMM:            w = M_COUT | M_ZIN | aluf;
                K_UN:             w = M_ZLOW | M_GRA | M_RIN;
                K_MD:             w = M_GRB | M_ROUT | M_ZIN | aluf;
                K_LD, K_LDI, K_ST: w = M_COUT | M_ZIN | 29'd3;
                default: ;
            endcase
            5: case (kd)
                K_RR, K_IMM, K_LDI: w = M_ZLOW | M_GRA | M_RIN;
                K_MD:               w = M_ZLOW | M_LOIN;
                K_LD, K_ST:         w = M_ZLOW | M_MARIN;
                default: ;
            endcase
            6: case (kd)
                K_MD: w = M_ZHIGH | M_HIIN;
                K_LD: w = M_READ | M_MDRIN;
                K_ST: w = M_GRA | M_ROUT | M_MDRIN;
                default: ;
            endcase
            7: case (kd)
                K_LD: w = M_MDROUT | M_GRA | M_RIN;
                K_ST: w = M_WRITE;
                default: ;
            endcase
            default: ;
        endcase
        return w;
    endfunction

    // Model: 0 = reset, 1 = executing step m_idx of the current instruction, 2 = halted.
    int unsigned m_mode = 0;
    int unsigned m_idx = 0;
    bit          m_sticky = 1'b0;

    task automatic model_step();
        if (!Reset_n) begin
            m_mode = 0; m_sticky = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_idx = 0;
        end else if (m_mode == 1) begin
            if (m_idx == 2 && kind_of(IR[31:27]) == K_HALT) begin
                m_mode = 2; m_sticky = 1'b1;
            end else if (m_idx + 1 == inst_len(IR[31:27])) begin
                m_mode = Stop ? 2 : 1; m_idx = 0;
            end else begin
                m_idx++;
            end
        end else if (!m_sticky && !Stop) begin
            m_mode = 1; m_idx = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [28:0] ew = (m_mode == 1) ? exp_word(IR[31:27], m_idx) : '0;
        check_val({tag, " ctrl"}, {3'd0, obs_word}, {3'd0, ew});
        check_val({tag, " Run"}, {31'd0, Run}, {31'd0, (m_mode == 1)});
    endtask

    logic [31:0] directed[$] = '{32'h2891_8000, 32'h0080_0000, 32'h7918_0000,
                                 32'hF800_0000, 32'h1080_0000, 32'hD800_0000};
    bit st_reset_done = 1'b0;

    initial begin
        repeat (2) @(negedge Clock);
        check_outputs("reset");
        Reset_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge Clock);
            model_step();
            @(negedge Clock);
            check_outputs($sformatf("cyc%0d", cyc));
            if (m_mode == 1 && m_idx == 0) begin
                if (directed.size() > 0) IR = directed.pop_front();
                else IR = $urandom;
            end
            Stop = ($urandom_range(0, 99) < 20);
            if (!Reset_n) begin
                Reset_n = 1'b1;
            end else if ((m_mode == 2 && m_sticky && $urandom_range(0, 3) == 0) ||
                         (!st_reset_done && m_mode == 1 && m_idx == 4 &&
                          kind_of(IR[31:27]) == K_ST) ||
                         $urandom_range(0, 199) == 0) begin
                if (m_mode == 1 && kind_of(IR[31:27]) == K_ST && m_idx == 4)
                    st_reset_done = 1'b1;
                Reset_n = 1'b0;
                m_mode = 0; m_sticky = 1'b0;
                #1;
                check_outputs($sformatf("async_reset%0d", cyc));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
